// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined multi-lane multiplier: default sizes,
// lane-slice offset helper and the default per-stage payload layout.
package mult_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_LANES      = 4;

  // Low bit of lane `lane` in a vector packed with `width` bits per lane.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Per-stage payload at default sizes: one full-width product per lane.
  typedef logic [DEF_LANES-1:0][2*DEF_DATA_WIDTH-1:0] payload_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// One elastic register stage: holds a valid bit and a data word, loads when
// downstream can take its content or when it is empty.
module mult_pipe_stage
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv_in,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             adv_out,
  output logic             v_out,
  output logic [WIDTH-1:0] d_out
);

  logic             v_reg;
  logic [WIDTH-1:0] d_reg;

  // An empty stage may always load, which lets bubbles collapse.
  assign adv_out = adv_in | ~v_reg;
  assign v_out   = v_reg;
  assign d_out   = d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_reg <= 1'b0;
      d_reg <= '0;
    end else begin
      if (flush)
        v_reg <= 1'b0;
      else if (adv_out)
        v_reg <= v_in;
      if (adv_out && v_in)
        d_reg <= d_in;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Multi-lane pipelined integer multiplier with valid/ready flow control,
// per-beat signed/unsigned mode, bubble collapsing and synchronous flush.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int LATENCY    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_signed,
  input  logic [LANES*DATA_WIDTH-1:0]   opa,
  input  logic [LANES*DATA_WIDTH-1:0]   opb,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*LANES*DATA_WIDTH-1:0] out_data,
  output logic                          busy
);

  localparam int PW = 2 * LANES * DATA_WIDTH;

  logic [LANES-1:0][2*DATA_WIDTH-1:0] prod;
  logic [LATENCY-1:0]                 v;
  logic [PW-1:0]                      d [LATENCY];
  // adv[k] = stage k may load; adv[LATENCY] is the downstream acceptance.
  logic                               adv [LATENCY+1];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam int LO = lane_lo(gi, DATA_WIDTH);
      logic [DATA_WIDTH-1:0]   a;
      logic [DATA_WIDTH-1:0]   b;
      logic [2*DATA_WIDTH-1:0] a_ext;
      logic [2*DATA_WIDTH-1:0] b_ext;
      assign a     = opa[LO +: DATA_WIDTH];
      assign b     = opb[LO +: DATA_WIDTH];
      // Extending both operands to the full product width makes the low
      // 2*DATA_WIDTH bits of a plain multiply exact in either mode.
      assign a_ext = {{DATA_WIDTH{in_signed & a[DATA_WIDTH-1]}}, a};
      assign b_ext = {{DATA_WIDTH{in_signed & b[DATA_WIDTH-1]}}, b};
      assign prod[gi] = a_ext * b_ext;
    end

    assign adv[LATENCY] = out_ready;

    for (gi = 0; gi < LATENCY; gi++) begin : g_stage
      logic          v_in;
      logic [PW-1:0] d_in;
      if (gi == 0) begin : g_first
        assign v_in = in_valid;
        assign d_in = prod;
      end else begin : g_rest
        assign v_in = v[gi-1];
        assign d_in = d[gi-1];
      end

      mult_pipe_stage #(
        .WIDTH (PW)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .adv_in  (adv[gi+1]),
        .v_in    (v_in),
        .d_in    (d_in),
        .adv_out (adv[gi]),
        .v_out   (v[gi]),
        .d_out   (d[gi])
      );
    end
  endgenerate

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v[LATENCY-1];
  assign out_data  = d[LATENCY-1];
  assign busy      = |v;

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: randomized beats scored against an
// arithmetic reference model with accept/transfer cycle stamps.
module tb_mult_pipe;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_signed = 1'b0;
  logic [LN*DW-1:0] opa = '0;
  logic [LN*DW-1:0] opb = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2*LN*DW-1:0] out_data;
  logic             busy;

  typedef struct {
    logic [2*LN*DW-1:0] data;
    int                 cyc;
  } rec_t;

  rec_t exp_q[$];
  rec_t got_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mult_pipe #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Reference: each lane is an integer multiply of the (optionally signed) operands.
  function automatic logic [2*LN*DW-1:0] model(input logic [LN*DW-1:0] a,
                                               input logic [LN*DW-1:0] b,
                                               input logic s);
    logic [2*LN*DW-1:0] r;
    logic signed [DW-1:0] sa, sb;
    longint x, y, p;
    r = '0;
    for (int l = 0; l < LN; l++) begin
      sa = a[DW*l +: DW];
      sb = b[DW*l +: DW];
      x  = s ? longint'(sa) : longint'({48'd0, a[DW*l +: DW]});
      y  = s ? longint'(sb) : longint'({48'd0, b[DW*l +: DW]});
      p  = x * y;
      r[2*DW*l +: 2*DW] = p[2*DW-1:0];
    end
    return r;
  endfunction

  // Advance one clock: record accepts and transfers just before the edge.
  task automatic step();
    rec_t r;
    @(negedge clk);
    if (in_valid && in_ready) begin
      r.data = model(opa, opb, in_signed);
      r.cyc  = cyc;
      exp_q.push_back(r);
    end
    if (out_valid && out_ready) begin
      r.data = out_data;
      r.cyc  = cyc;
      got_q.push_back(r);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && got_q.size() < exp_q.size(); i++) step();
    step();
  endtask

  task automatic rand_ops();
    opa = {$urandom, $urandom};
    opb = {$urandom, $urandom};
  endtask

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    $display("reset: out_valid=%b busy=%b in_ready=%b", out_valid, busy, in_ready);
  endtask

  task automatic test_stream();
    clear_q();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_signed = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      if (i == 0) begin
        opa[15:0] = 16'h8000; opb[15:0] = 16'h8000;
        opa[31:16] = 16'hFFFF; opb[31:16] = 16'h0002;
      end
      step();
    end
    drain(20);
    n_vec++; if (got_q.size() != 8) begin n_err++; $display("FAIL stream_count got %0d want 8", got_q.size()); end
    if (got_q.size() > 0) begin
      n_vec++; if (got_q[0].data[31:0] !== 32'h4000_0000) begin n_err++; $display("FAIL stream_lane0 got %h want 40000000", got_q[0].data[31:0]); end
      n_vec++; if (got_q[0].data[63:32] !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL stream_lane1 got %h want fffffffe", got_q[0].data[63:32]); end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i].data !== exp_q[i].data) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, got_q[i].data, exp_q[i].data); end
      n_vec++; if (got_q[i].cyc - exp_q[i].cyc != LAT) begin n_err++; $display("FAIL stream_latency[%0d] got %0d want %0d", i, got_q[i].cyc - exp_q[i].cyc, LAT); end
      if (i > 0) begin
        n_vec++; if (got_q[i].cyc != got_q[i-1].cyc + 1) begin n_err++; $display("FAIL stream_rate[%0d] gap %0d want 1", i, got_q[i].cyc - got_q[i-1].cyc); end
      end
    end
    $display("stream: %0d beats out", got_q.size());
  endtask

  task automatic test_interleave();
    logic [31:0] want;
    clear_q();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    opa = '1;
    opb = '1;
    for (int i = 0; i < 6; i++) begin
      in_signed = i[0];
      step();
    end
    drain(20);
    n_vec++; if (got_q.size() != 6) begin n_err++; $display("FAIL interleave_count got %0d want 6", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      want = i[0] ? 32'h0000_0001 : 32'hFFFE_0001;
      for (int l = 0; l < LN; l++) begin
        n_vec++; if (got_q[i].data[32*l +: 32] !== want) begin n_err++; $display("FAIL interleave[%0d] lane%0d got %h want %h", i, l, got_q[i].data[32*l +: 32], want); end
      end
    end
    $display("interleave: %0d beats out", got_q.size());
  endtask

  task automatic test_backpressure();
    clear_q();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_signed = 1'b0;
    for (int i = 0; i < 6; i++) begin rand_ops(); in_signed = $urandom_range(0, 1); step(); end
    n_vec++; if (exp_q.size() != LAT) begin n_err++; $display("FAIL bp_accepted got %0d want %0d", exp_q.size(), LAT); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    rand_ops();
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_full_ready got %b want 1", in_ready); end
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin rand_ops(); step(); end
    n_vec++; if (exp_q.size() != LAT + 1 || got_q.size() != 1) begin n_err++; $display("FAIL bp_one_slot got acc=%0d out=%0d want acc=%0d out=1", exp_q.size(), got_q.size(), LAT + 1); end
    drain(20);
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL bp_count got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (got_q[i].data !== exp_q[i].data) begin n_err++; $display("FAIL bp_data[%0d] got %h want %h", i, got_q[i].data, exp_q[i].data); end
    end
    $display("backpressure: accepted %0d, delivered %0d", exp_q.size(), got_q.size());
  endtask

  task automatic test_bubble();
    clear_q();
    out_ready = 1'b0;
    in_signed = 1'b1;
    in_valid  = 1'b1; rand_ops(); step();
    in_valid  = 1'b0; step(); step();
    in_valid  = 1'b1; rand_ops(); step();
    in_valid  = 1'b0; repeat (3) step();
    n_vec++; if (exp_q.size() != 2 || got_q.size() != 0 || busy !== 1'b1) begin n_err++; $display("FAIL bubble_hold got acc=%0d out=%0d busy=%b want 2 0 1", exp_q.size(), got_q.size(), busy); end
    drain(20);
    n_vec++; if (got_q.size() != 2) begin n_err++; $display("FAIL bubble_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_vec++; if (got_q[1].cyc != got_q[0].cyc + 1) begin n_err++; $display("FAIL bubble_consecutive gap %0d want 1", got_q[1].cyc - got_q[0].cyc); end
      for (int i = 0; i < 2; i++) begin
        n_vec++; if (got_q[i].data !== exp_q[i].data) begin n_err++; $display("FAIL bubble_data[%0d] got %h want %h", i, got_q[i].data, exp_q[i].data); end
      end
    end
    $display("bubble: delivered %0d", got_q.size());
  endtask

  task automatic test_flush_reset();
    clear_q();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < LAT; i++) begin rand_ops(); step(); end
    flush = 1'b1;
    rand_ops();
    #1;
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy got %b want 0", busy); end
    n_vec++; if (exp_q.size() != LAT) begin n_err++; $display("FAIL flush_accepted got %0d want %0d", exp_q.size(), LAT); end
    clear_q();
    out_ready = 1'b1;
    repeat (5) step();
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL flush_stale got %0d beats want 0", got_q.size()); end
    $display("flush: busy=%b stale=%0d", busy, got_q.size());

    clear_q();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < LAT; i++) begin rand_ops(); step(); end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_clear got v=%b busy=%b want 0 0", out_valid, busy); end
    step();
    rst_n = 1'b1;
    clear_q();
    out_ready = 1'b1;
    repeat (5) step();
    n_vec++; if (got_q.size() != 0) begin n_err++; $display("FAIL midreset_stale got %0d beats want 0", got_q.size()); end
    in_valid = 1'b1; in_signed = 1'b1; rand_ops(); step();
    drain(20);
    n_vec++; if (got_q.size() != 1) begin n_err++; $display("FAIL midreset_first got %0d beats want 1", got_q.size()); end
    if (got_q.size() == 1 && exp_q.size() == 1) begin
      n_vec++; if (got_q[0].data !== exp_q[0].data || got_q[0].cyc - exp_q[0].cyc != LAT) begin n_err++; $display("FAIL midreset_beat got %h lat %0d want %h lat %0d", got_q[0].data, got_q[0].cyc - exp_q[0].cyc, exp_q[0].data, LAT); end
    end
    $display("midreset: first beat after reset delivered %0d", got_q.size());
  endtask

  initial begin
    test_reset();
    test_stream();
    test_interleave();
    test_backpressure();
    test_bubble();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
